// File: rtl/issue_sched_if.sv
// Issue scheduler handshake bundle: instruction-buffer head pair,
// branch/memory status in, issue/stop/flush controls out.
interface issue_sched_if;
  logic       i0_valid;
  logic       i1_valid;
  logic [1:0] i0_cls;
  logic [1:0] i1_cls;
  logic       i0_we;
  logic       i1_we;
  logic [4:0] i0_rd;
  logic [4:0] i0_rs1;
  logic [4:0] i0_rs2;
  logic [4:0] i1_rd;
  logic [4:0] i1_rs1;
  logic [4:0] i1_rs2;
  logic       br_resolve;
  logic       br_taken;
  logic       mem_done;
  logic [1:0] consume;
  logic       ex1_issue;
  logic       ex1_sel;
  logic       ex2_issue;
  logic       ex2_sel;
  logic       mem_req;
  logic       de_ex_stop;
  logic       ex_wb_stop;
  logic       de_ex_flush;
  logic       ibuf_flush;
  logic       timeout_err;

  modport master (
    output i0_valid, i1_valid, i0_cls, i1_cls,
    output i0_we, i1_we, i0_rd, i0_rs1, i0_rs2,
    output i1_rd, i1_rs1, i1_rs2,
    output br_resolve, br_taken, mem_done,
    input  consume, ex1_issue, ex1_sel,
    input  ex2_issue, ex2_sel, mem_req,
    input  de_ex_stop, ex_wb_stop, de_ex_flush,
    input  ibuf_flush, timeout_err
  );

  modport slave (
    input  i0_valid, i1_valid, i0_cls, i1_cls,
    input  i0_we, i1_we, i0_rd, i0_rs1, i0_rs2,
    input  i1_rd, i1_rs1, i1_rs2,
    input  br_resolve, br_taken, mem_done,
    output consume, ex1_issue, ex1_sel,
    output ex2_issue, ex2_sel, mem_req,
    output de_ex_stop, ex_wb_stop, de_ex_flush,
    output ibuf_flush, timeout_err
  );
endinterface

// File: rtl/issue_sched.sv
// Dual-issue scheduler: load-use/RAW/WAW checks, memory wait, flush.
// Dual issue is enabled by defining ISSUE_DUAL_EN.
module issue_sched #(
  parameter int MAX_MEM_WAIT = 15
) (
  input logic         clk,
  input logic         rst,
  issue_sched_if.slave bus
);

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    FLUSH
  } state_t;

`ifdef ISSUE_DUAL_EN
  localparam bit DUAL = 1'b1;
`else
  localparam bit DUAL = 1'b0;
`endif

  localparam logic [7:0] WD_LIM = 8'(MAX_MEM_WAIT - 1);

  state_t     state;
  state_t     nxt;
  logic       ex_load_v;
  logic [4:0] ex_load_rd;
  logic       mem_pend;
  logic [7:0] cnt;
  logic       tmo;

  logic wait_st, wd, done_eff, br_go;
  logic stop, can_issue;
  logic haz0, haz1;
  logic i0_mem, i0_br, i1_mem, i1_br, i1_alu;
  logic unit_ok, i1_to_ex2, raw_ok, waw_ok;
  logic i0_go, i1_go;
  logic mem_issue, load_issue;
  logic [4:0] load_rd;

  assign wait_st  = (state == MEM_WAIT);
  assign wd       = wait_st && !bus.mem_done
                    && (cnt == WD_LIM);
  assign done_eff = bus.mem_done || wd;

  // A watchdog completion never carries a branch redirect.
  assign br_go = !rst && bus.br_resolve
                 && bus.br_taken
                 && ((state == RUN)
                     || (wait_st && bus.mem_done));

  assign stop = !rst && wait_st && !done_eff;
  assign can_issue = !rst && !br_go
                     && ((state == RUN)
                         || (wait_st && done_eff));

  assign haz0 = ex_load_v && (ex_load_rd != 5'd0)
                && ((bus.i0_rs1 == ex_load_rd)
                    || (bus.i0_rs2 == ex_load_rd));
  assign haz1 = ex_load_v && (ex_load_rd != 5'd0)
                && ((bus.i1_rs1 == ex_load_rd)
                    || (bus.i1_rs2 == ex_load_rd));

  assign i0_mem = (bus.i0_cls == 2'b10);
  assign i0_br  = (bus.i0_cls == 2'b01);
  assign i1_mem = (bus.i1_cls == 2'b10);
  assign i1_br  = (bus.i1_cls == 2'b01);
  assign i1_alu = !i1_mem && !i1_br;

  // An ALU/NOP i1 takes whichever unit i0 left idle.
  assign i1_to_ex2 = i1_mem || (i1_alu && !i0_mem);
  assign unit_ok   = i1_br  ? i0_mem :
                     i1_mem ? !i0_mem : 1'b1;

  assign raw_ok = !(bus.i0_we && (bus.i0_rd != 5'd0)
                    && ((bus.i1_rs1 == bus.i0_rd)
                        || (bus.i1_rs2 == bus.i0_rd)));
  assign waw_ok = !(bus.i0_we && bus.i1_we
                    && (bus.i1_rd == bus.i0_rd));

  assign i0_go = can_issue && bus.i0_valid && !haz0;
  assign i1_go = DUAL && i0_go && bus.i1_valid
                 && !i0_br && unit_ok
                 && raw_ok && waw_ok && !haz1;

  assign mem_issue  = (i0_go && i0_mem)
                      || (i1_go && i1_mem);
  assign load_issue = (i0_go && i0_mem && bus.i0_we)
                      || (i1_go && i1_mem && bus.i1_we);
  assign load_rd    = (i0_go && i0_mem) ? bus.i0_rd
                                        : bus.i1_rd;

  assign bus.ex1_issue = (i0_go && !i0_mem)
                         || (i1_go && !i1_to_ex2);
  assign bus.ex1_sel   = i1_go && !i1_to_ex2;
  assign bus.ex2_issue = (i0_go && i0_mem)
                         || (i1_go && i1_to_ex2);
  assign bus.ex2_sel   = i1_go && i1_to_ex2;
  assign bus.consume   = {1'b0, i0_go}
                         + {1'b0, i1_go};
  assign bus.mem_req     = !rst && mem_pend;
  assign bus.de_ex_stop  = stop;
  assign bus.ex_wb_stop  = stop;
  assign bus.de_ex_flush = !stop && !i0_go;
  assign bus.ibuf_flush  = br_go
                           || (!rst && state == FLUSH);
  assign bus.timeout_err = !rst && tmo;

  always_comb begin
    nxt = state;
    unique case (state)
      RUN: begin
        if (br_go)          nxt = FLUSH;
        else if (mem_issue) nxt = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (br_go)         nxt = FLUSH;
        else if (done_eff) nxt = mem_issue ? MEM_WAIT
                                           : RUN;
      end
      FLUSH:   nxt = RUN;
      default: nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      ex_load_v  <= 1'b0;
      ex_load_rd <= 5'd0;
      mem_pend   <= 1'b0;
      cnt        <= 8'd0;
      tmo        <= 1'b0;
    end else begin
      state <= nxt;
      if (!stop) begin
        ex_load_v <= load_issue;
        mem_pend  <= mem_issue;
        if (load_issue) ex_load_rd <= load_rd;
      end
      cnt <= stop ? cnt + 8'd1 : 8'd0;
      if (wd) tmo <= 1'b1;
    end
  end

endmodule

// File: doc/issue_sched.md
ISSUE_SCHED -- requirements
Module: issue_sched

Interface
REQ-001 Parameter MAX_MEM_WAIT, default 15, is the memory-wait watchdog limit in cycles (1..255).
REQ-002 Ports (clock and reset first):
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- i0_valid, i1_valid  in  1 each  instruction-buffer head (i0, older) and next (i1) are valid.
- i0_cls, i1_cls  in  2 each  instruction class: 00 ALU, 01 BR, 10 MEM, 11 NOP (NOP goes to ex1 as ALU).
- i0_we, i1_we  in  1 each  instruction writes rd; MEM with we=1 is a load.
- i0_rd, i0_rs1, i0_rs2, i1_rd, i1_rs1, i1_rs2  in  5 each  register indices.
- br_resolve, br_taken  in  1 each  branch in ex1 resolved this cycle / redirect required.
- mem_done  in  1  MEM operation in ex2 completes this cycle.
- consume  out  2  instructions popped from the buffer this cycle (0, 1 or 2).
- ex1_issue, ex1_sel  out  1 each  drive ALU/branch unit; sel 0=i0, 1=i1.
- ex2_issue, ex2_sel  out  1 each  drive ALU/memory unit; sel 0=i0, 1=i1.
- mem_req  out  1  MEM operation pending in ex2.
- de_ex_stop, ex_wb_stop  out  1 each  hold the DE/EX and EX/WB pipeline registers.
- de_ex_flush  out  1  zero the DE/EX registers (bubble).
- ibuf_flush  out  1  discard the instruction buffer.
- timeout_err  out  1  sticky watchdog error.

Function
REQ-003 FSM states: RUN, MEM_WAIT, FLUSH; all issue/stop/flush outputs are combinational from inputs and registered state.
REQ-004 Load-use hazard: a candidate with rs1 or rs2 equal to the registered ex_load_rd, while ex_load_v=1 and ex_load_rd!=0, does not issue that cycle.
REQ-005 In RUN, i0 issues if valid and hazard-free: ALU/BR/NOP to ex1 (sel 0), MEM to ex2 (sel 0).
REQ-006 i1 issues in the same cycle only if all hold: i0 issued; i1 valid; i0 not BR; the unit i1 needs is free (ALU to whichever unit i0 left free; BR only to ex1; MEM only to ex2); i1 rs1/rs2 do not match i0_rd when i0_we=1 and i0_rd!=0; i1_rd differs from i0_rd when both we=1; no load-use hazard.
REQ-007 i1 never issues without i0; consume equals the number issued; i0 not issued makes consume=0 and de_ex_flush=1 (bubble).
REQ-008 Issuing MEM registers mem_pend=1; the next cycle enters MEM_WAIT; a load also sets ex_load_v=1 and ex_load_rd=its rd, otherwise ex_load_v clears on every non-stopped cycle.
REQ-009 In MEM_WAIT: mem_req=1, de_ex_stop=1, ex_wb_stop=1, consume=0, no issue; wait counter increments each cycle; br_taken is ignored.
REQ-010 mem_done in MEM_WAIT: stops deassert the same cycle and the counter clears; with br_resolve&br_taken high, the branch rule applies, otherwise issue proceeds as in RUN and the FSM returns to RUN (or MEM_WAIT again if MEM issues).
REQ-011 Watchdog expiry (counter reaches MAX_MEM_WAIT without mem_done):
- timeout_err=1 until rst.
- Treated as mem_done without a branch.
REQ-012 Branch rule (RUN, or MEM_WAIT completion), br_resolve&br_taken:
- de_ex_flush=1, ibuf_flush=1, consume=0, no issue; ex_load_v clears.
- Next state FLUSH.
- Takes priority over issue.
REQ-013 FLUSH lasts exactly one cycle: no issue, consume=0, de_ex_flush=1; then RUN.
REQ-014 br_resolve with br_taken=0 has no effect.

Reset
REQ-015 While rst=1, all outputs are 0 except de_ex_flush=1; the next state is RUN, and ex_load_v, mem_pend, counter and timeout_err are all 0.
REQ-016 rst during MEM_WAIT or FLUSH abandons the operation; the first post-reset cycle is RUN with no pending memory.

Configuration
REQ-017 Macro ISSUE_DUAL_EN:
- Defined: REQ-006 dual issue is enabled.
- Undefined: i1 never issues, consume<=1, ex*_sel always 0; all other behaviour is identical.

Verification
REQ-018 All scenarios run with ISSUE_DUAL_EN defined unless stated.
- i0 ALU rd=5, i1 MEM load rd=6 rs1=2 -> ex1_issue=1 sel0, ex2_issue=1 sel1, consume=2.
- i0 ALU rd=5 we=1, i1 ALU rs1=5 -> only i0 issues, consume=1; next cycle i1 as i0 issues.
- Load rd=7 issued, mem_done after 3 cycles, next i0 rs2=7 -> 3 cycles with stops=1 and consume=0; on done cycle i0 blocked by load-use, issues one cycle later.
- br_taken with i0/i1 valid -> ibuf_flush=1, de_ex_flush=1 and consume=0 for 2 cycles (branch + FLUSH), then issue resumes.
- MAX_MEM_WAIT=4, mem_done never -> timeout_err=1 after 4 MEM_WAIT cycles, RUN resumes; rst clears it.
- ISSUE_DUAL_EN undefined, the first scenario -> consume=1 for two consecutive cycles.
